// File: rtl/game_pkg.sv
// Shared definitions for the brick-smasher round countdown.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    localparam int unsigned MAX_SECONDS = 599;  // 9:59
    localparam int          BCD_W       = 4;
    localparam int          SEC_W       = 10;   // holds 0..1023, enough for 599+59

    // Fold an M:SS BCD triple into a plain seconds count.
    function automatic logic [SEC_W-1:0] mmss_to_secs(input logic [BCD_W-1:0] m,
                                                      input logic [BCD_W-1:0] t,
                                                      input logic [BCD_W-1:0] o);
        return SEC_W'(m) * SEC_W'(60) + SEC_W'(t) * SEC_W'(10) + SEC_W'(o);
    endfunction

endpackage

// File: rtl/game_countdown_mmss_adjust.sv
// Combinational M:SS adjuster: optional -1 s and +inc s, clamped to 9:59.
module mmss_adjust
    import game_pkg::*;
(
    input  logic [BCD_W-1:0] min_i,
    input  logic [BCD_W-1:0] tens_i,
    input  logic [BCD_W-1:0] ones_i,
    input  logic             dec_i,
    input  logic [5:0]       inc_i,
    output logic [BCD_W-1:0] min_o,
    output logic [BCD_W-1:0] tens_o,
    output logic [BCD_W-1:0] ones_o,
    output logic             zero_o
);

    logic [SEC_W:0]   sum;
    logic [SEC_W-1:0] secs;
    logic [SEC_W-1:0] q_min;
    logic [SEC_W-1:0] rem;
    logic [SEC_W-1:0] q_tens;
    logic [SEC_W-1:0] q_ones;

    // Add first, then take the tick, then clamp: tick+bonus nets to +(bonus-1)
    // before saturation. The decrement is floored at zero so it can never wrap.
    always_comb begin
        sum = {1'b0, mmss_to_secs(min_i, tens_i, ones_i)} + (SEC_W+1)'(inc_i);
        if (dec_i && (sum != '0)) begin
            sum = sum - (SEC_W+1)'(1);
        end
        if (sum > (SEC_W+1)'(MAX_SECONDS)) begin
            sum = (SEC_W+1)'(MAX_SECONDS);
        end
        secs   = sum[SEC_W-1:0];
        q_min  = secs / SEC_W'(60);
        rem    = secs - q_min * SEC_W'(60);
        q_tens = rem / SEC_W'(10);
        q_ones = rem - q_tens * SEC_W'(10);
    end

    assign min_o  = BCD_W'(q_min);
    assign tens_o = BCD_W'(q_tens);
    assign ones_o = BCD_W'(q_ones);
    assign zero_o = (secs == '0) && (sum[SEC_W] == 1'b0);

endmodule

// File: rtl/game_countdown.sv
// Round clock FSM: BCD M:SS countdown with pause, restart, bonus and timeout.
module game_countdown
    import game_pkg::*;
#(
    parameter int unsigned INIT_MIN  = 2,
    parameter int unsigned INIT_SEC  = 0,
    parameter int unsigned BONUS_SEC = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             pause,
    input  logic             restart,
    input  logic             bonus,
    output logic             timer_en,
    output logic [BCD_W-1:0] min_bcd,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             running,
    output logic             timeout,
    output logic             done
);

    localparam logic [BCD_W-1:0] INIT_M    = BCD_W'(INIT_MIN);
    localparam logic [BCD_W-1:0] INIT_T    = BCD_W'(INIT_SEC / 10);
    localparam logic [BCD_W-1:0] INIT_O    = BCD_W'(INIT_SEC % 10);
    localparam logic             INIT_ZERO = (INIT_MIN == 0) && (INIT_SEC == 0);
    localparam logic [5:0]       BONUS     = 6'(BONUS_SEC);

    state_e           state_q;
    logic [BCD_W-1:0] min_q, tens_q, ones_q;
    logic             done_q;

    logic             adj_dec;
    logic [5:0]       adj_inc;
    logic [BCD_W-1:0] min_d, tens_d, ones_d;
    logic             zero_d;

    // Ticks only count in RUN; bonus lands in RUN or PAUSE.
    always_comb begin
        adj_dec = tick && (state_q == ST_RUN);
        adj_inc = (bonus && ((state_q == ST_RUN) || (state_q == ST_PAUSE))) ? BONUS : 6'd0;
    end

    mmss_adjust u_adj (
        .min_i  (min_q),
        .tens_i (tens_q),
        .ones_i (ones_q),
        .dec_i  (adj_dec),
        .inc_i  (adj_inc),
        .min_o  (min_d),
        .tens_o (tens_d),
        .ones_o (ones_d),
        .zero_o (zero_d)
    );

    // Round FSM and digit registers; restart beats pause beats start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            min_q   <= INIT_M;
            tens_q  <= INIT_T;
            ones_q  <= INIT_O;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (restart) begin
                state_q <= ST_IDLE;
                min_q   <= INIT_M;
                tens_q  <= INIT_T;
                ones_q  <= INIT_O;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && !pause) begin
                            if (INIT_ZERO) begin
                                state_q <= ST_EXPIRED;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_RUN;
                            end
                        end
                    end
                    ST_RUN: begin
                        min_q  <= min_d;
                        tens_q <= tens_d;
                        ones_q <= ones_d;
                        // Expiry outranks a same-cycle pause.
                        if (tick && zero_d) begin
                            state_q <= ST_EXPIRED;
                            done_q  <= 1'b1;
                        end else if (pause) begin
                            state_q <= ST_PAUSE;
                        end
                    end
                    ST_PAUSE: begin
                        min_q  <= min_d;
                        tens_q <= tens_d;
                        ones_q <= ones_d;
                        if (start && !pause) begin
                            state_q <= ST_RUN;
                        end
                    end
                    ST_EXPIRED: begin
                        if (start && !pause) begin
                            min_q  <= INIT_M;
                            tens_q <= INIT_T;
                            ones_q <= INIT_O;
                            if (INIT_ZERO) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= ST_RUN;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign timer_en = (state_q == ST_RUN);
    assign running  = (state_q == ST_RUN);
    assign timeout  = (state_q == ST_EXPIRED);
    assign min_bcd  = min_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign done     = done_q;

endmodule

// File: tb/tb_game_countdown.sv
// Randomized + directed bench for game_countdown against a seconds-count model.
module tb_game_countdown;

    localparam int INIT_S = 120;  // 2:00
    localparam int BONUS  = 10;
    localparam int MAXS   = 599;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0, start = 1'b0, pause = 1'b0, restart = 1'b0, bonus = 1'b0;
    logic       timer_en, running, timeout, done;
    logic [3:0] min_bcd, sec_tens, sec_ones;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: plain seconds and a phase name
    int m_secs;
    int m_phase;  // 0 idle, 1 running, 2 paused, 3 expired
    bit m_done;

    game_countdown dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .start    (start),
        .pause    (pause),
        .restart  (restart),
        .bonus    (bonus),
        .timer_en (timer_en),
        .min_bcd  (min_bcd),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .timeout  (timeout),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".min"},  int'(min_bcd),  m_secs / 60);
        chk({tag, ".tens"}, int'(sec_tens), (m_secs % 60) / 10);
        chk({tag, ".ones"}, int'(sec_ones), m_secs % 10);
        chk({tag, ".ten"},  int'(timer_en), int'(m_phase == 1));
        chk({tag, ".run"},  int'(running),  int'(m_phase == 1));
        chk({tag, ".tout"}, int'(timeout),  int'(m_phase == 3));
        chk({tag, ".done"}, int'(done),     int'(m_done));
    endtask

    function automatic void model_reset();
        m_secs = INIT_S; m_phase = 0; m_done = 0;
    endfunction

    function automatic void model_step(bit t, bit s, bit p, bit r, bit b);
        int v;
        m_done = 0;
        if (r) begin
            m_secs = INIT_S; m_phase = 0;
            return;
        end
        case (m_phase)
            0: if (s && !p) begin
                   if (INIT_S == 0) begin m_phase = 3; m_done = 1; end
                   else m_phase = 1;
               end
            1: begin
                   v = m_secs + (b ? BONUS : 0) - (t ? 1 : 0);
                   if (v > MAXS) v = MAXS;
                   if (v < 0) v = 0;
                   m_secs = v;
                   if (t && v == 0) begin m_phase = 3; m_done = 1; end
                   else if (p) m_phase = 2;
               end
            2: begin
                   if (b) m_secs = (m_secs + BONUS > MAXS) ? MAXS : m_secs + BONUS;
                   if (s && !p) m_phase = 1;
               end
            default: if (s && !p) begin
                   m_secs = INIT_S;
                   if (INIT_S == 0) m_done = 1;
                   else m_phase = 1;
               end
        endcase
    endfunction

    task automatic step(input string tag, input bit t, input bit s, input bit p,
                        input bit r, input bit b);
        @(negedge clk);
        tick = t; start = s; pause = p; restart = r; bonus = b;
        @(posedge clk);
        #1;
        model_step(t, s, p, r, b);
        check_all(tag);
        tick = 0; start = 0; pause = 0; restart = 0; bonus = 0;
    endtask

    task automatic ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1, 0, 0, 0, 0);
    endtask

    initial begin
        // Power-on reset
        reset = 1'b1;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Ticks in IDLE are ignored, then run three seconds
        ticks("idle_tick", 3);
        step("start", 0, 1, 0, 0, 0);
        ticks("run3", 3);
        ticks("to137", 20);

        // Asynchronous reset mid-run at 1:37
        chk("at137", m_secs, 97);
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_all("post_rst");

        // Borrow chains, then expiry coincident with pause
        step("start2", 0, 1, 0, 0, 0);
        ticks("to100", 60);
        ticks("min_borrow", 1);
        ticks("to010", 49);
        ticks("tens_borrow", 1);
        ticks("to001", 8);
        step("expire_pause", 1, 0, 1, 0, 0);
        step("exp_hold", 1, 0, 0, 0, 1);
        step("exp_hold2", 1, 0, 0, 0, 0);
        step("exp_start", 0, 1, 0, 0, 0);

        // Pause at 1:20, bonus while paused, resume
        ticks("to120", 40);
        step("pause", 0, 0, 1, 0, 0);
        ticks("paused_tick", 3);
        step("paused_bonus", 1, 0, 0, 0, 1);
        step("resume", 0, 1, 0, 0, 0);

        // Saturation at 9:59
        step("restart", 0, 0, 0, 1, 0);
        step("start3", 0, 1, 0, 0, 0);
        for (int i = 0; i < 48; i++) step("bonus_up", 0, 0, 0, 0, 1);
        ticks("to955", 4);
        step("sat", 1, 0, 0, 0, 1);
        chk("sat959", int'(min_bcd) * 100 + int'(sec_tens) * 10 + int'(sec_ones), 959);

        // 0:05 + bonus + tick -> 0:14
        step("restart2", 0, 0, 0, 1, 0);
        step("start4", 0, 1, 0, 0, 0);
        ticks("to005", 115);
        step("bonus_tick", 1, 0, 0, 0, 1);
        chk("b14", int'(min_bcd) * 100 + int'(sec_tens) * 10 + int'(sec_ones), 14);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom_range(0, 1) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 5) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
